// File: rtl/cache_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_port_arbiter_if : request/response bundle between two masters,     |
// |                         the arbiter and the cache CPU port               |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) ();
  logic              m0_valid;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_stopped;
  logic              m0_rsp_valid;
  logic              m1_valid;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_stopped;
  logic              m1_rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              cache_valid;
  logic              cache_rw;
  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_stopped;
  logic              cache_ready;
  logic [DATA_W-1:0] cache_rdata;
  logic              err_unexpected_rsp;

  // Arbiter side.
  modport slave (
    input  m0_valid, m0_rw, m0_addr, m0_wdata,
    input  m1_valid, m1_rw, m1_addr, m1_wdata,
    input  cache_stopped, cache_ready, cache_rdata,
    output m0_stopped, m0_rsp_valid, m1_stopped, m1_rsp_valid, rsp_data,
    output cache_valid, cache_rw, cache_addr, cache_wdata, err_unexpected_rsp
  );

  // Environment side: requesting masters plus the cache.
  modport master (
    output m0_valid, m0_rw, m0_addr, m0_wdata,
    output m1_valid, m1_rw, m1_addr, m1_wdata,
    output cache_stopped, cache_ready, cache_rdata,
    input  m0_stopped, m0_rsp_valid, m1_stopped, m1_rsp_valid, rsp_data,
    input  cache_valid, cache_rw, cache_addr, cache_wdata, err_unexpected_rsp
  );
endinterface
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cache_port_arbiter : round-robin two-master arbiter for the cache CPU    |
// |                      port, with in-order read-response routing FIFO      |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cache_port_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  cache_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e       lock_state_q, lock_state_d;
  logic              lock_id_q, lock_id_d;
  logic              rr_q, rr_d;
  logic              err_q, err_d;
  logic [DEPTH-1:0]  fifo_q, fifo_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              has_room;
  logic              elig0, elig1;
  logic              req_any;
  logic              sel;
  logic              accept;
  logic              push, pop;
  logic              head;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Selection: a stalled request keeps the port until the cache takes it.
  always_comb begin
    has_room = (count_q != FULL_CNT);
    elig0    = bus.m0_valid && (bus.m0_rw || has_room);
    elig1    = bus.m1_valid && (bus.m1_rw || has_room);
    sel      = 1'b0;
    req_any  = 1'b0;
    if (lock_state_q == ST_LOCKED) begin
      sel     = lock_id_q;
      req_any = 1'b1;
    end else if (elig0 && elig1) begin
      sel     = rr_q;
      req_any = 1'b1;
    end else if (elig1) begin
      sel     = 1'b1;
      req_any = 1'b1;
    end else if (elig0) begin
      sel     = 1'b0;
      req_any = 1'b1;
    end
    sel_rw    = sel ? bus.m1_rw    : bus.m0_rw;
    sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;
    accept    = !rst && req_any && !bus.cache_stopped;
    push      = accept && !sel_rw;
    pop       = bus.cache_ready && (count_q != '0);
    head      = fifo_q[rd_ptr_q];
  end

  assign bus.cache_valid        = !rst && req_any;
  assign bus.cache_rw           = sel_rw;
  assign bus.cache_addr         = sel_addr;
  assign bus.cache_wdata        = sel_wdata;
  assign bus.m0_stopped         = !rst && bus.m0_valid && !(accept && !sel);
  assign bus.m1_stopped         = !rst && bus.m1_valid && !(accept && sel);
  assign bus.m0_rsp_valid       = pop && !head;
  assign bus.m1_rsp_valid       = pop && head;
  assign bus.rsp_data           = bus.cache_rdata;
  assign bus.err_unexpected_rsp = err_q;

  always_comb begin
    lock_state_d = lock_state_q;
    lock_id_d    = lock_id_q;
    rr_d         = rr_q;
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    err_d        = err_q || (bus.cache_ready && (count_q == '0));

    if (accept) begin
      rr_d         = ~sel;
      lock_state_d = ST_OPEN;
    end else if (req_any && bus.cache_stopped) begin
      lock_state_d = ST_LOCKED;
      lock_id_d    = sel;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = sel;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_state_q <= ST_OPEN;
      lock_id_q    <= 1'b0;
      rr_q         <= 1'b0;
      err_q        <= 1'b0;
      fifo_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_id_q    <= lock_id_d;
      rr_q         <= rr_d;
      err_q        <= err_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cache_port_arbiter : directed scenarios plus randomized traffic       |
// |                         against a queue-based model of the arbiter       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cache_port_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  cache_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cache_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic set_m0(input logic v, input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.m0_valid = v; bus.m0_rw = rw; bus.m0_addr = a; bus.m0_wdata = d;
  endtask

  task automatic set_m1(input logic v, input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.m1_valid = v; bus.m1_rw = rw; bus.m1_addr = a; bus.m1_wdata = d;
  endtask

  task automatic idle_inputs();
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
    bus.cache_stopped = 1'b0;
    bus.cache_ready   = 1'b0;
    bus.cache_rdata   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_m0(1'b1, 1'b0, 20'h00010, '0);
    set_m1(1'b1, 1'b1, 20'h00020, 32'h1);
    @(negedge clk); #1;
    checks++; if (bus.cache_valid !== 1'b0) begin failures++; $display("FAIL rst_cache_valid got=%b exp=0", bus.cache_valid); end
    checks++; if (bus.m0_stopped !== 1'b0) begin failures++; $display("FAIL rst_m0_stopped got=%b exp=0", bus.m0_stopped); end
    checks++; if (bus.m1_stopped !== 1'b0) begin failures++; $display("FAIL rst_m1_stopped got=%b exp=0", bus.m1_stopped); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    set_m0(1'b0, 1'b0, 20'h00123, '0);
    set_m1(1'b0, 1'b0, 20'h00456, '0);
    #1;
    checks++; if (bus.cache_valid !== 1'b0) begin failures++; $display("FAIL idle_cache_valid got=%b exp=0", bus.cache_valid); end
    checks++; if (bus.cache_addr !== 20'h00123) begin failures++; $display("FAIL idle_mux_m0 got=%h exp=00123", bus.cache_addr); end
    checks++; if (bus.err_unexpected_rsp !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err_unexpected_rsp); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic exp_sel;
    logic last;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      set_m0(k < 6, 1'b0, 20'h00010, '0);
      set_m1(k < 6, 1'b0, 20'h00020, '0);
      bus.cache_ready = (k > 0);
      bus.cache_rdata = 32'h1000 + k;
      #1;
      if (k < 6) begin
        exp_sel = (k % 2 == 1);
        checks++; if (bus.cache_valid !== 1'b1) begin failures++; $display("FAIL rr_valid k%0d got=%b exp=1", k, bus.cache_valid); end
        checks++; if (bus.cache_addr !== (exp_sel ? 20'h00020 : 20'h00010)) begin failures++; $display("FAIL rr_addr k%0d got=%h", k, bus.cache_addr); end
        checks++; if (bus.m0_stopped !== exp_sel) begin failures++; $display("FAIL rr_m0_stopped k%0d got=%b exp=%b", k, bus.m0_stopped, exp_sel); end
        checks++; if (bus.m1_stopped !== !exp_sel) begin failures++; $display("FAIL rr_m1_stopped k%0d got=%b exp=%b", k, bus.m1_stopped, !exp_sel); end
      end
      if (k > 0) begin
        last = ((k - 1) % 2 == 1);
        checks++; if (bus.m0_rsp_valid !== !last) begin failures++; $display("FAIL rr_rsp0 k%0d got=%b exp=%b", k, bus.m0_rsp_valid, !last); end
        checks++; if (bus.m1_rsp_valid !== last) begin failures++; $display("FAIL rr_rsp1 k%0d got=%b exp=%b", k, bus.m1_rsp_valid, last); end
        checks++; if (bus.rsp_data !== 32'h1000 + k) begin failures++; $display("FAIL rr_rsp_data k%0d got=%h", k, bus.rsp_data); end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_stall_lock();
    do_reset();
    set_m1(1'b1, 1'b1, 20'h00005, 32'hDEADBEEF);
    bus.cache_stopped = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) set_m0(1'b1, 1'b0, 20'h00040, '0);
      #1;
      checks++; if (bus.cache_addr !== 20'h00005) begin failures++; $display("FAIL stall_addr c%0d got=%h exp=00005", c, bus.cache_addr); end
      checks++; if (bus.cache_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL stall_wdata c%0d got=%h", c, bus.cache_wdata); end
      checks++; if (bus.m1_stopped !== 1'b1) begin failures++; $display("FAIL stall_m1_stopped c%0d got=%b exp=1", c, bus.m1_stopped); end
      checks++; if (bus.m0_stopped !== (c >= 1)) begin failures++; $display("FAIL stall_m0_stopped c%0d got=%b", c, bus.m0_stopped); end
      @(negedge clk);
    end
    bus.cache_stopped = 1'b0;
    #1;
    checks++; if (bus.cache_addr !== 20'h00005 || bus.cache_rw !== 1'b1) begin failures++; $display("FAIL stall_release_addr got=%h rw=%b exp=00005/1", bus.cache_addr, bus.cache_rw); end
    checks++; if (bus.m1_stopped !== 1'b0 || bus.m0_stopped !== 1'b1) begin failures++; $display("FAIL stall_release_stopped got m0=%b m1=%b exp 1/0", bus.m0_stopped, bus.m1_stopped); end
    @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0);
    #1;
    checks++; if (bus.cache_addr !== 20'h00040 || bus.cache_rw !== 1'b0) begin failures++; $display("FAIL stall_next_addr got=%h rw=%b exp=00040/0", bus.cache_addr, bus.cache_rw); end
    checks++; if (bus.m0_stopped !== 1'b0) begin failures++; $display("FAIL stall_next_m0 got=%b exp=0", bus.m0_stopped); end
    @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0);
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'h0000CAFE;
    #1;
    checks++; if (bus.m0_rsp_valid !== 1'b1 || bus.m1_rsp_valid !== 1'b0) begin failures++; $display("FAIL stall_rsp got m0=%b m1=%b exp 1/0", bus.m0_rsp_valid, bus.m1_rsp_valid); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_m0(1'b1, 1'b0, 20'(256 + i), '0);
      #1;
      checks++; if (bus.m0_stopped !== 1'b0 || bus.cache_addr !== 20'(256 + i)) begin failures++; $display("FAIL full_fill i%0d stopped=%b addr=%h", i, bus.m0_stopped, bus.cache_addr); end
      @(negedge clk);
    end
    set_m0(1'b1, 1'b0, 20'h00104, '0);
    set_m1(1'b1, 1'b1, 20'h00300, 32'h55);
    #1;
    checks++; if (bus.m0_stopped !== 1'b1) begin failures++; $display("FAIL full_read_stopped got=%b exp=1", bus.m0_stopped); end
    checks++; if (bus.m1_stopped !== 1'b0 || bus.cache_addr !== 20'h00300 || bus.cache_rw !== 1'b1) begin failures++; $display("FAIL full_write_pass stopped=%b addr=%h rw=%b", bus.m1_stopped, bus.cache_addr, bus.cache_rw); end
    @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0);
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'hA0;
    #1;
    checks++; if (bus.m0_rsp_valid !== 1'b1) begin failures++; $display("FAIL full_pop_rsp got=%b exp=1", bus.m0_rsp_valid); end
    checks++; if (bus.m0_stopped !== 1'b1 || bus.cache_valid !== 1'b0) begin failures++; $display("FAIL full_pop_same_cycle stopped=%b valid=%b exp 1/0", bus.m0_stopped, bus.cache_valid); end
    @(negedge clk);
    bus.cache_ready = 1'b0;
    #1;
    checks++; if (bus.m0_stopped !== 1'b0 || bus.cache_addr !== 20'h00104) begin failures++; $display("FAIL full_fifth_accept stopped=%b addr=%h", bus.m0_stopped, bus.cache_addr); end
    @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      bus.cache_ready = 1'b1;
      #1;
      checks++; if (bus.m0_rsp_valid !== 1'b1 || bus.m1_rsp_valid !== 1'b0) begin failures++; $display("FAIL full_drain i%0d m0=%b m1=%b", i, bus.m0_rsp_valid, bus.m1_rsp_valid); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_read_order();
    logic [DATA_W-1:0] dat [3];
    logic              own [3];
    dat = '{32'h11, 32'h22, 32'h33};
    own = '{1'b0, 1'b1, 1'b0};
    do_reset();
    set_m0(1'b1, 1'b0, 20'h00100, '0); #1;
    checks++; if (bus.m0_stopped !== 1'b0 || bus.cache_addr !== 20'h00100) begin failures++; $display("FAIL ord_req0 stopped=%b addr=%h", bus.m0_stopped, bus.cache_addr); end
    @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0); set_m1(1'b1, 1'b0, 20'h00200, '0); #1;
    checks++; if (bus.m1_stopped !== 1'b0 || bus.cache_addr !== 20'h00200) begin failures++; $display("FAIL ord_req1 stopped=%b addr=%h", bus.m1_stopped, bus.cache_addr); end
    @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0); set_m0(1'b1, 1'b0, 20'h00300, '0); #1;
    checks++; if (bus.m0_stopped !== 1'b0 || bus.cache_addr !== 20'h00300) begin failures++; $display("FAIL ord_req2 stopped=%b addr=%h", bus.m0_stopped, bus.cache_addr); end
    @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      bus.cache_ready = 1'b1;
      bus.cache_rdata = dat[i];
      #1;
      checks++; if (bus.m0_rsp_valid !== !own[i] || bus.m1_rsp_valid !== own[i]) begin failures++; $display("FAIL ord_rsp i%0d m0=%b m1=%b exp_owner=%0d", i, bus.m0_rsp_valid, bus.m1_rsp_valid, own[i]); end
      checks++; if (bus.rsp_data !== dat[i]) begin failures++; $display("FAIL ord_data i%0d got=%h exp=%h", i, bus.rsp_data, dat[i]); end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_unexpected_rsp();
    do_reset();
    bus.cache_ready = 1'b1;
    bus.cache_rdata = 32'h1;
    #1;
    checks++; if (bus.m0_rsp_valid !== 1'b0 || bus.m1_rsp_valid !== 1'b0) begin failures++; $display("FAIL unexp_rsp_valid m0=%b m1=%b exp 0/0", bus.m0_rsp_valid, bus.m1_rsp_valid); end
    @(negedge clk);
    bus.cache_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.err_unexpected_rsp !== 1'b1) begin failures++; $display("FAIL unexp_err_sticky c%0d got=%b exp=1", c, bus.err_unexpected_rsp); end
      @(negedge clk);
    end
    do_reset();
    #1;
    checks++; if (bus.err_unexpected_rsp !== 1'b0) begin failures++; $display("FAIL unexp_err_cleared got=%b exp=0", bus.err_unexpected_rsp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_m1(1'b1, 1'b0, 20'h00200, '0);
    @(negedge clk);
    set_m1(1'b0, 1'b0, '0, '0); set_m0(1'b1, 1'b0, 20'h00100, '0);
    @(negedge clk);
    set_m0(1'b0, 1'b0, '0, '0); set_m1(1'b1, 1'b1, 20'h00005, 32'h7);
    bus.cache_stopped = 1'b1;
    #1;
    checks++; if (bus.m1_stopped !== 1'b1 || bus.cache_addr !== 20'h00005) begin failures++; $display("FAIL rmid_stall stopped=%b addr=%h", bus.m1_stopped, bus.cache_addr); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.cache_valid !== 1'b0 || bus.m1_stopped !== 1'b0) begin failures++; $display("FAIL rmid_mask valid=%b m1_stopped=%b exp 0/0", bus.cache_valid, bus.m1_stopped); end
    @(negedge clk);
    rst = 1'b0;
    bus.cache_stopped = 1'b0;
    set_m0(1'b1, 1'b0, 20'h00111, '0);
    set_m1(1'b1, 1'b0, 20'h00222, '0);
    bus.cache_ready = 1'b1;
    #1;
    checks++; if (bus.cache_addr !== 20'h00111 || bus.m0_stopped !== 1'b0 || bus.m1_stopped !== 1'b1) begin failures++; $display("FAIL rmid_tie addr=%h m0=%b m1=%b", bus.cache_addr, bus.m0_stopped, bus.m1_stopped); end
    checks++; if (bus.m0_rsp_valid !== 1'b0 || bus.m1_rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_stale_rsp m0=%b m1=%b exp 0/0", bus.m0_rsp_valid, bus.m1_rsp_valid); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (bus.err_unexpected_rsp !== 1'b1) begin failures++; $display("FAIL rmid_err got=%b exp=1", bus.err_unexpected_rsp); end
    @(negedge clk);
  endtask

  // Model: outstanding reads as a queue of issuer IDs, a held grant while stalled,
  // and the tie-break favouring whoever was not served last.
  task automatic test_random();
    int                issuers [$];
    bit                held, held_id, favour;
    bit                pv [2];
    bit                prw [2];
    logic [ADDR_W-1:0] pa [2];
    logic [DATA_W-1:0] pd [2];
    bit                ok0, ok1, any, who, acc, rdy, exp0, exp1;
    logic [DATA_W-1:0] rdat;
    do_reset();
    held = 1'b0; held_id = 1'b0; favour = 1'b0;
    pv = '{1'b0, 1'b0};
    for (int c = 0; c < 400; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pv[m] && $urandom_range(0, 1) == 1) begin
          pv[m]  = 1'b1;
          prw[m] = ($urandom_range(0, 2) == 0);
          pa[m]  = ADDR_W'($urandom);
          pd[m]  = $urandom;
        end
      end
      set_m0(pv[0], prw[0], pa[0], pd[0]);
      set_m1(pv[1], prw[1], pa[1], pd[1]);
      bus.cache_stopped = ($urandom_range(0, 3) == 0);
      rdy  = (issuers.size() > 0) && ($urandom_range(0, 1) == 1);
      rdat = $urandom;
      bus.cache_ready = rdy;
      bus.cache_rdata = rdat;
      #1;
      ok0 = pv[0] && (prw[0] || issuers.size() < DEPTH);
      ok1 = pv[1] && (prw[1] || issuers.size() < DEPTH);
      any = 1'b1;
      who = 1'b0;
      if (held) who = held_id;
      else if (ok0 && ok1) who = favour;
      else if (ok1) who = 1'b1;
      else if (ok0) who = 1'b0;
      else any = 1'b0;
      acc  = any && !bus.cache_stopped;
      exp0 = rdy && (issuers.size() > 0) && (issuers[0] == 0);
      exp1 = rdy && (issuers.size() > 0) && (issuers[0] == 1);
      checks++; if (bus.cache_valid !== any) begin failures++; $display("FAIL rnd_valid c%0d got=%b exp=%b", c, bus.cache_valid, any); end
      if (any) begin
        checks++; if (bus.cache_addr !== pa[who] || bus.cache_rw !== prw[who]) begin failures++; $display("FAIL rnd_mux c%0d addr=%h rw=%b exp=%h/%b", c, bus.cache_addr, bus.cache_rw, pa[who], prw[who]); end
        if (prw[who]) begin
          checks++; if (bus.cache_wdata !== pd[who]) begin failures++; $display("FAIL rnd_wdata c%0d got=%h exp=%h", c, bus.cache_wdata, pd[who]); end
        end
      end
      checks++; if (bus.m0_stopped !== (pv[0] && !(acc && who == 1'b0))) begin failures++; $display("FAIL rnd_m0_stopped c%0d got=%b", c, bus.m0_stopped); end
      checks++; if (bus.m1_stopped !== (pv[1] && !(acc && who == 1'b1))) begin failures++; $display("FAIL rnd_m1_stopped c%0d got=%b", c, bus.m1_stopped); end
      checks++; if (bus.m0_rsp_valid !== exp0 || bus.m1_rsp_valid !== exp1) begin failures++; $display("FAIL rnd_rsp c%0d got=%b%b exp=%b%b", c, bus.m0_rsp_valid, bus.m1_rsp_valid, exp0, exp1); end
      checks++; if (bus.rsp_data !== rdat) begin failures++; $display("FAIL rnd_rsp_data c%0d got=%h exp=%h", c, bus.rsp_data, rdat); end
      if (rdy && issuers.size() > 0) void'(issuers.pop_front());
      if (acc) begin
        if (!prw[who]) issuers.push_back(int'(who));
        favour  = !who;
        held    = 1'b0;
        pv[who] = 1'b0;
      end else if (any) begin
        held    = 1'b1;
        held_id = who;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.err_unexpected_rsp !== 1'b0) begin failures++; $display("FAIL rnd_err got=%b exp=0", bus.err_unexpected_rsp); end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall_lock();
    test_fifo_full();
    test_read_order();
    test_unexpected_rsp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
